// File: rtl/video_pkg.sv
// Shared video constants: default 640x480@60 timing, pixel type, framebuffer geometry.
package video_pkg;

    typedef logic [7:0] rgb332_t;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;

    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;

    // Framebuffer geometry; the RAM instance uses the same constants so depths agree.
    localparam int unsigned FB_WIDTH_DEF    = 128;
    localparam int unsigned FB_HEIGHT_DEF   = 64;
    localparam int unsigned SCALE_SHIFT_DEF = 2;
    localparam rgb332_t     BORDER_DEF      = 8'h00;

endpackage

// File: rtl/video_timing.sv
// Raster counters plus active/hsync/vsync decode for the current raster position.
module video_timing
    import video_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned HW      = $clog2(H_TOTAL),
    localparam int unsigned VW      = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ce,
    output logic [HW-1:0] hcount,
    output logic [VW-1:0] vcount,
    output logic          active,
    output logic          hs,
    output logic          vs
);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
    localparam logic [HW-1:0] HS_START   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] VS_START   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);

    // Advance the raster one pixel per ce; vcount steps on hcount wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount <= '0;
            vcount <= '0;
        end else if (ce) begin
            if (hcount == H_LAST) begin
                hcount <= '0;
                vcount <= (vcount == V_LAST) ? '0 : vcount + 1'b1;
            end else begin
                hcount <= hcount + 1'b1;
            end
        end
    end

    // Decode region flags for the current position.
    always_comb begin
        active = (hcount < H_ACT) && (vcount < V_ACT);
        hs     = (hcount >= HS_START) && (hcount < HS_END);
        vs     = (vcount >= VS_START) && (vcount < VS_END);
    end

endmodule

// File: rtl/fb_scanout.sv
// Framebuffer scanout: maps raster position to RAM address, then aligns RAM data with
// delayed timing flags through two ce-gated stages.
module fb_scanout
    import video_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
    parameter int unsigned H_FP        = H_FP_DEF,
    parameter int unsigned H_SYNC      = H_SYNC_DEF,
    parameter int unsigned H_BP        = H_BP_DEF,
    parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF,
    parameter int unsigned V_FP        = V_FP_DEF,
    parameter int unsigned V_SYNC      = V_SYNC_DEF,
    parameter int unsigned V_BP        = V_BP_DEF,
    parameter int unsigned FB_WIDTH    = FB_WIDTH_DEF,
    parameter int unsigned FB_HEIGHT   = FB_HEIGHT_DEF,
    parameter int unsigned SCALE_SHIFT = SCALE_SHIFT_DEF,
    parameter rgb332_t     BORDER      = BORDER_DEF,
    localparam int unsigned ADDRESS_WIDTH_B = $clog2(FB_WIDTH * FB_HEIGHT)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ce,
    output logic [ADDRESS_WIDTH_B-1:0] addr_b,
    input  rgb332_t                    q_b,
    output rgb332_t                    pixel,
    output logic                       de,
    output logic                       hsync,
    output logic                       vsync,
    output logic                       vblank
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned FBW_W   = $clog2(FB_WIDTH);
    localparam int unsigned FBH_W   = $clog2(FB_HEIGHT);

    localparam logic [HW-1:0] FB_W_LIM  = HW'(FB_WIDTH);
    localparam logic [VW-1:0] FB_H_LIM  = VW'(FB_HEIGHT);
    localparam logic [VW-1:0] V_LAST_ACT = VW'(V_ACTIVE - 1);

    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;
    logic          active, hs, vs;
    logic [HW-1:0] fbx;
    logic [VW-1:0] fby;
    logic          inwin;

    logic    active1, inwin1, hs1, vs1, last1;
    logic    ce_d;
    rgb332_t q_hold;
    rgb332_t q_cur;

    video_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk    (clk),
        .rst_n  (rst_n),
        .ce     (ce),
        .hcount (hcount),
        .vcount (vcount),
        .active (active),
        .hs     (hs),
        .vs     (vs)
    );

    // Window test and byte address for the current raster position.
    always_comb begin
        fbx    = hcount >> SCALE_SHIFT;
        fby    = vcount >> SCALE_SHIFT;
        inwin  = active && (fbx < FB_W_LIM) && (fby < FB_H_LIM);
        addr_b = inwin ? {fby[FBH_W-1:0], fbx[FBW_W-1:0]} : '0;
    end

    // Stage 1: delay region flags to line up with the RAM read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active1 <= 1'b0;
            inwin1  <= 1'b0;
            hs1     <= 1'b0;
            vs1     <= 1'b0;
            last1   <= 1'b0;
        end else if (ce) begin
            active1 <= active;
            inwin1  <= inwin;
            hs1     <= hs;
            vs1     <= vs;
            last1   <= (vcount == V_LAST_ACT);
        end
    end

    // Capture RAM data on the clk after a ce; addr_b moves on after the ce, so later
    // clks in a ce gap would otherwise return the next pixel's byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ce_d   <= 1'b0;
            q_hold <= '0;
        end else begin
            ce_d <= ce;
            if (ce_d) begin
                q_hold <= q_b;
            end
        end
    end

    // Data for the stage-1 pixel: live when ce came back-to-back, else the held copy.
    always_comb begin
        q_cur = ce_d ? q_b : q_hold;
    end

    // Stage 2 output registers; vblank pulses for one clk as de leaves the last active line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel  <= '0;
            de     <= 1'b0;
            hsync  <= 1'b0;
            vsync  <= 1'b0;
            vblank <= 1'b0;
        end else begin
            vblank <= ce && de && !active1 && last1;
            if (ce) begin
                pixel <= !active1 ? '0 : (inwin1 ? q_cur : BORDER);
                de    <= active1;
                hsync <= hs1;
                vsync <= vs1;
            end
        end
    end

endmodule
